// File: rtl/clock_interface_pkg.sv
// ---------------------------------------------------------------------------
// clock_interface_pkg
// Shared constants for the push-button clock stepping block.
//   - 3-bit FSM state encodings for the four-phase core clock sequencer
//   - key index constants into the 2-bit key_n bus
// ---------------------------------------------------------------------------
package clock_interface_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t PH0  = 3'd1;
  localparam state_t PH1  = 3'd2;
  localparam state_t PH2  = 3'd3;
  localparam state_t PH3  = 3'd4;

  localparam int unsigned KEY_STEP = 1;
  localparam int unsigned KEY_RUN  = 0;

endpackage

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// Synchronises one active-low push button into clk, filters contact bounce
// and emits a single-cycle pulse on each accepted released->pressed change.
//
// Ports
//   clk    in  : sampling clock
//   rst    in  : synchronous reset, active-high
//   key_n  in  : raw button, active-low, asynchronous
//   press  out : one-cycle registered pulse on an accepted press
//
// Parameter
//   DEBOUNCE_CYCLES : consecutive disagreeing samples needed to accept a level
// ---------------------------------------------------------------------------
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;   // 1 = pressed
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          sample_pressed;

  assign sample_pressed = ~sync2_q;

  // Counter only advances while the sample disagrees with the accepted level;
  // any agreeing sample clears it, so only an unbroken run is accepted.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sample_pressed != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sample_pressed;
        press_d = sample_pressed;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_step_interface.sv
// ---------------------------------------------------------------------------
// clock_step_interface
// Turns the DE-board step and run/pause buttons into the core_clk / mem_clk
// pair for the core. Each core cycle is four phases of PHASE_CYCLES:
//   state | meaning
//   IDLE  | clocks low, waiting for a step press or run mode
//   PH0   | core_clk=1 mem_clk=0
//   PH1   | core_clk=1 mem_clk=1
//   PH2   | core_clk=0 mem_clk=1
//   PH3   | core_clk=0 mem_clk=0, then PH0 (run) or IDLE (step)
//
// Ports
//   clk         in  : board oscillator, only clock
//   rst         in  : synchronous reset, active-high
//   key_n[1:0]  in  : raw buttons, active-low ([1] step, [0] run toggle)
//   core_clk    out : registered core clock
//   mem_clk     out : registered memory clock
//   run_mode    out : 1 free-running, 0 single-step
//   busy        out : high while a sequence is in progress
//   cycle_count out : completed core_clk rising edges
//
// Build option
//   CLOCK_STEP_COUNTER_EN : when defined, cycle_count is a live 32-bit
//                           counter; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module clock_step_interface
  import clock_interface_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned PHASE_CYCLES    = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  key_n,
  output logic        core_clk,
  output logic        mem_clk,
  output logic        run_mode,
  output logic        busy,
  output logic [31:0] cycle_count
);

  localparam int unsigned PW = $clog2(PHASE_CYCLES + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(PHASE_CYCLES - 1);

  logic [1:0]    press_w;
  state_t        state_q, state_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic          run_mode_q, run_mode_d;
  logic          core_clk_q, mem_clk_q, busy_q;
  logic          phase_tc;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n[KEY_STEP]),
    .press (press_w[KEY_STEP])
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n[KEY_RUN]),
    .press (press_w[KEY_RUN])
  );

  assign phase_tc = (phase_cnt_q == '0);

  // Step presses outside IDLE fall through the case untouched, so they are
  // dropped rather than queued. run_mode is sampled from the flop, so a run
  // press in the same cycle as a step press in IDLE still lets the step start.
  always_comb begin
    run_mode_d = run_mode_q ^ press_w[KEY_RUN];
    state_d    = state_q;
    case (state_q)
      IDLE: if (run_mode_q || press_w[KEY_STEP]) state_d = PH0;
      PH0:  if (phase_tc) state_d = PH1;
      PH1:  if (phase_tc) state_d = PH2;
      PH2:  if (phase_tc) state_d = PH3;
      PH3:  if (phase_tc) state_d = run_mode_q ? PH0 : IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      phase_cnt_d = PH_LAST;
    end else if (phase_tc) begin
      phase_cnt_d = '0;
    end else begin
      phase_cnt_d = phase_cnt_q - PW'(1);
    end
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state and never depend combinationally on pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      run_mode_q  <= 1'b0;
      core_clk_q  <= 1'b0;
      mem_clk_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      run_mode_q  <= run_mode_d;
      core_clk_q  <= (state_d == PH0) || (state_d == PH1);
      mem_clk_q   <= (state_d == PH1) || (state_d == PH2);
      busy_q      <= (state_d != IDLE);
    end
  end

`ifdef CLOCK_STEP_COUNTER_EN
  logic [31:0] cycle_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_q <= '0;
    end else if ((state_d == PH0) && (state_q != PH0)) begin
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = 32'd0;
`endif

  assign core_clk = core_clk_q;
  assign mem_clk  = mem_clk_q;
  assign run_mode = run_mode_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_clock_step_interface.sv
// ---------------------------------------------------------------------------
// tb_clock_step_interface
// Scoreboarded bench: each expected core cycle is queued when its key
// stimulus is driven and popped when core_clk rises. Waveform spacing within
// every sequence is measured against the rising edge of core_clk.
// Honours CLOCK_STEP_COUNTER_EN for the expected cycle_count values.
// ---------------------------------------------------------------------------
module tb_clock_step_interface;

  localparam int unsigned DEB = 4;
  localparam int unsigned PH  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  key_n = 2'b11;
  logic        core_clk, mem_clk, run_mode, busy;
  logic [31:0] cycle_count;

  clock_step_interface #(.DEBOUNCE_CYCLES(DEB), .PHASE_CYCLES(PH)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .core_clk    (core_clk),
    .mem_clk     (mem_clk),
    .run_mode    (run_mode),
    .busy        (busy),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cnt;
    int          gap;
  } exp_t;

  exp_t        sb_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          t_rise  = 0;
  int          t_prev_rise = 0;
  int          n_rise  = 0;
  int          n_step_press = 0;
  int          n_run_press  = 0;
  int          step_press_cyc = 0;
  logic        mon_en = 1'b0;
  logic        core_prev = 1'b0, mem_prev = 1'b0, busy_prev = 1'b0;
  logic [31:0] model_cnt = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_count(input logic [31:0] m);
`ifdef CLOCK_STEP_COUNTER_EN
    return m;
`else
    return (m & 32'd0);
`endif
  endfunction

  task automatic push_seq(input int gap);
    exp_t e;
    model_cnt = model_cnt + 32'd1;
    e.cnt = exp_count(model_cnt);
    e.gap = gap;
    sb_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (core_clk && !core_prev) begin
        t_rise = cyc;
        n_rise++;
        if (sb_q.size() == 0) begin
          chk("unexpected_seq", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("seq_count", cycle_count, e.cnt);
          if (e.gap != 0) chk("seq_gap", 32'(cyc - t_prev_rise), 32'(e.gap));
          chk("busy_at_rise", {31'd0, busy}, 32'd1);
        end
        t_prev_rise = cyc;
      end
      if (!core_clk && core_prev) chk("core_fall", 32'(cyc - t_rise), 32'(2 * PH));
      if (mem_clk && !mem_prev)   chk("mem_rise",  32'(cyc - t_rise), 32'(PH));
      if (!mem_clk && mem_prev)   chk("mem_fall",  32'(cyc - t_rise), 32'(3 * PH));
      if (!busy && busy_prev)     chk("busy_fall", 32'(cyc - t_rise), 32'(4 * PH));
      if (dut.press_w[1]) begin
        n_step_press++;
        step_press_cyc = cyc;
      end
      if (dut.press_w[0]) n_run_press++;
    end
    core_prev = core_clk;
    mem_prev  = mem_clk;
    busy_prev = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    n_rise = 0;
    n_step_press = 0;
    n_run_press = 0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    key_n  = 2'b11;
    rst    = 1'b1;
    tick(2);
    rst    = 1'b0;
    model_cnt = 32'd0;
    sb_q.delete();
    tick(1);
    clr_stats();
    mon_en = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int i;
    i = 0;
    while ((sb_q.size() != 0 || busy) && i < lim) begin
      tick(1);
      i++;
    end
    chk(tag, {31'd0, (i < lim)}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int i;

    // Reset state
    rst = 1'b1;
    tick(3);
    chk("rst_core", {31'd0, core_clk}, 32'd0);
    chk("rst_mem",  {31'd0, mem_clk},  32'd0);
    chk("rst_busy", {31'd0, busy},     32'd0);
    chk("rst_run",  {31'd0, run_mode}, 32'd0);
    chk("rst_cnt",  cycle_count,       32'd0);
    do_reset();

    // 1: single step press held for 10 cycles
    push_seq(0);
    key_n[1] = 1'b0;
    f = cyc;
    tick(10);
    key_n[1] = 1'b1;
    wait_idle("t1_timeout", 40);
    tick(8);
    chk("t1_press_n",   32'(n_step_press), 32'd1);
    chk("t1_press_cyc", 32'(step_press_cyc), 32'(f + 6));
    chk("t1_core_rise", 32'(t_rise), 32'(f + 7));
    chk("t1_rises",     32'(n_rise), 32'd1);
    chk("t1_cnt",       cycle_count, exp_count(32'd1));

    // 2: bouncing key never accepted
    clr_stats();
    for (i = 0; i < 10; i++) begin
      key_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    key_n[1] = 1'b1;
    tick(12);
    chk("t2_press_n", 32'(n_step_press), 32'd0);
    chk("t2_rises",   32'(n_rise), 32'd0);
    chk("t2_core",    {31'd0, core_clk}, 32'd0);
    chk("t2_cnt",     cycle_count, exp_count(32'd1));

    // 3: second step press during PH1 is discarded
    do_reset();
    push_seq(0);
    key_n[1] = 1'b0;
    f = cyc;
    i = 0;
    while (!(core_clk && mem_clk) && i < 30) begin
      tick(1);
      if (cyc >= f + 7) key_n[1] = 1'b1;
      i++;
    end
    chk("t3_reach_ph1", {31'd0, (i < 30)}, 32'd1);
    key_n[1] = 1'b1;
    force dut.u_deb_step.press_q = 1'b1;
    tick(1);
    release dut.u_deb_step.press_q;
    wait_idle("t3_timeout", 40);
    tick(10);
    chk("t3_rises", 32'(n_rise), 32'd1);
    chk("t3_cnt",   cycle_count, exp_count(32'd1));

    // 4: run mode, then pause mid-PH2 of the third sequence
    do_reset();
    push_seq(0);
    push_seq(8);
    push_seq(8);
    key_n[0] = 1'b0;
    f = cyc;
    tick(8);
    key_n[0] = 1'b1;
    while (cyc < f + 22) tick(1);
    chk("t4_run_on", {31'd0, run_mode}, 32'd1);
    key_n[0] = 1'b0;
    tick(8);
    key_n[0] = 1'b1;
    wait_idle("t4_timeout", 60);
    tick(10);
    chk("t4_run_off", {31'd0, run_mode}, 32'd0);
    chk("t4_rises",   32'(n_rise), 32'd3);
    chk("t4_run_n",   32'(n_run_press), 32'd2);
    chk("t4_busy",    {31'd0, busy}, 32'd0);
    chk("t4_cnt",     cycle_count, exp_count(32'd3));

    // 5: reset during PH1, then one clean step
    do_reset();
    push_seq(0);
    key_n[1] = 1'b0;
    f = cyc;
    i = 0;
    while (!(core_clk && mem_clk) && i < 30) begin
      tick(1);
      if (cyc >= f + 7) key_n[1] = 1'b1;
      i++;
    end
    chk("t5_reach_ph1", {31'd0, (i < 30)}, 32'd1);
    key_n[1] = 1'b1;
    mon_en = 1'b0;
    rst = 1'b1;
    tick(1);
    chk("t5_core", {31'd0, core_clk}, 32'd0);
    chk("t5_mem",  {31'd0, mem_clk},  32'd0);
    chk("t5_busy", {31'd0, busy},     32'd0);
    chk("t5_run",  {31'd0, run_mode}, 32'd0);
    chk("t5_cnt",  cycle_count,       32'd0);
    rst = 1'b0;
    sb_q.delete();
    model_cnt = 32'd0;
    tick(8);
    clr_stats();
    mon_en = 1'b1;
    push_seq(0);
    key_n[1] = 1'b0;
    tick(8);
    key_n[1] = 1'b1;
    wait_idle("t5_timeout", 40);
    tick(10);
    chk("t5_rises", 32'(n_rise), 32'd1);
    chk("t5_cnt2",  cycle_count, exp_count(32'd1));

    // 6: counter wrap
    do_reset();
`ifdef CLOCK_STEP_COUNTER_EN
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    tick(1);
    release dut.cycle_count_q;
    model_cnt = 32'hFFFF_FFFF;
`endif
    push_seq(0);
    key_n[1] = 1'b0;
    tick(8);
    key_n[1] = 1'b1;
    wait_idle("t6_timeout", 40);
    tick(8);
    chk("t6_rises", 32'(n_rise), 32'd1);
    chk("t6_wrap",  cycle_count, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
